uart_tx_arbiter: RTL

- Packet-atomic round-robin arbiter that shares the UART engine's TX path among NUM_REQ byte-stream requesters (register bridge, scope dump, log streamer, ...).
- Pulls bytes from the granted requester and writes them into the TX FIFO using the engine's edge-detected write interface.
- When the packet's last byte is written, issues one edge-detected start pulse to kick transmission.
- Sits between the requesters and uart_engine's TX FIFO/control ports.

---
 rtl/uart_tx_arbiter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter feeding the UART engine's edge-triggered TX FIFO write and start inputs.
// Every byte takes three cycles: it is accepted, the write strobe goes high, then the write strobe goes low.
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_DEPTH = 1024,
    parameter int TIMEOUT    = 65535
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [NUM_REQ-1:0]     s_valid,
    input  logic [8*NUM_REQ-1:0]   s_data,
    input  logic [NUM_REQ-1:0]     s_last,
    output logic [NUM_REQ-1:0]     s_ready,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy,
    output logic [7:0]             tx_fifo_data,
    output logic                   tx_fifo_wr_en,
    output logic                   tx_start_pulse,
    input  logic                   tx_fifo_full,
    input  logic [10:0]            tx_fifo_data_count,
    output logic [15:0]            pkt_count,
    output logic [15:0]            abort_count
);
    // state | meaning
    // IDLE  | no owner; arbitrate when enabled
    // LOAD  | owner granted; waiting to accept a byte
    // WR_HI | FIFO write strobe high
    // WR_LO | FIFO write strobe low; data still held
    // START | one-cycle start pulse; update counters; release grant
    // GAP   | start low for one cycle so the next start has a rising edge
    typedef enum logic [2:0] {IDLE, LOAD, WR_HI, WR_LO, START, GAP} state_t;

    localparam int          IDX_W     = $clog2(NUM_REQ);
    localparam logic [10:0] SPACE_LIM = 11'(FIFO_DEPTH - 2);
    localparam logic [15:0] TMO       = 16'(TIMEOUT);

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]     gidx_q, gidx_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [7:0]           byte_q, byte_d;
    logic                 last_q, last_d;
    logic [15:0]          timer_q, timer_d;
    logic                 abort_q, abort_d;
    logic [15:0]          pkt_count_q, pkt_count_d;
    logic [15:0]          abort_count_q, abort_count_d;

    logic                 space;
    logic                 sel_valid;
    logic                 sel_last;
    logic [7:0]           sel_data;
    logic [15:0]          timer_inc;
    logic                 pick_vld;
    logic [IDX_W-1:0]     pick_idx;
    logic [IDX_W-1:0]     cand;
    logic [NUM_REQ-1:0]   s_ready_c;
    logic                 wr_en_c;
    logic                 start_c;

    // Keep two entries of margin because the engine registers the write pulse one cycle late.
    assign space     = !tx_fifo_full && (tx_fifo_data_count < SPACE_LIM);
    assign sel_valid = s_valid[gidx_q];
    assign sel_last  = s_last[gidx_q];
    assign sel_data  = s_data[{gidx_q, 3'b000} +: 8];
    assign timer_inc = timer_q + 16'd1;

    // Search upward from ptr+1, wrapping, so the last owner gets the lowest priority.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!pick_vld && s_valid[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        gidx_d        = gidx_q;
        ptr_d         = ptr_q;
        byte_d        = byte_q;
        last_d        = last_q;
        timer_d       = timer_q;
        abort_d       = abort_q;
        pkt_count_d   = pkt_count_q;
        abort_count_d = abort_count_q;
        s_ready_c     = '0;
        wr_en_c       = 1'b0;
        start_c       = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && pick_vld) begin
                    grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                    gidx_d  = pick_idx;
                    timer_d = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (sel_valid && space) begin
                    s_ready_c = grant_q;
                    byte_d    = sel_data;
                    last_d    = sel_last;
                    timer_d   = '0;
                    state_d   = WR_HI;
                end else if (!sel_valid) begin
                    timer_d = timer_inc;
                    if (timer_inc == TMO) begin
                        abort_d = 1'b1;
                        state_d = START;
                    end
                end
            end
            WR_HI: begin
                wr_en_c = 1'b1;
                state_d = WR_LO;
            end
            WR_LO: begin
                state_d = last_q ? START : LOAD;
            end
            START: begin
                start_c = 1'b1;
                if (abort_q) abort_count_d = abort_count_q + 16'd1;
                else         pkt_count_d   = pkt_count_q + 16'd1;
                ptr_d   = gidx_q;
                grant_d = '0;
                abort_d = 1'b0;
                state_d = GAP;
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            gidx_q        <= '0;
            ptr_q         <= IDX_W'(NUM_REQ - 1);
            byte_q        <= '0;
            last_q        <= 1'b0;
            timer_q       <= '0;
            abort_q       <= 1'b0;
            pkt_count_q   <= '0;
            abort_count_q <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            gidx_q        <= gidx_d;
            ptr_q         <= ptr_d;
            byte_q        <= byte_d;
            last_q        <= last_d;
            timer_q       <= timer_d;
            abort_q       <= abort_d;
            pkt_count_q   <= pkt_count_d;
            abort_count_q <= abort_count_d;
        end
    end

    assign s_ready        = s_ready_c;
    assign grant          = grant_q;
    assign busy           = (state_q != IDLE);
    assign tx_fifo_data   = byte_q;
    assign tx_fifo_wr_en  = wr_en_c;
    assign tx_start_pulse = start_c;
    assign pkt_count      = pkt_count_q;
    assign abort_count    = abort_count_q;

endmodule
